// File: rtl/sseg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sseg_pkg
// Description : Shared constants for the seven-segment scan driver: the hex
//               glyph table (active-low {g,f,e,d,c,b,a}), the blank pattern
//               and the default refresh configuration.
// Revision    : 1.0 - initial release
// ============================================================================
package sseg_pkg;

    // Board-level defaults: 8 digits, 100 MHz clock, 1 kHz per digit.
    localparam int MAX_DIGITS          = 8;
    localparam int DEFAULT_REFRESH_DIV = 100000;
    localparam int DEFAULT_CNT_W       = 17;

    // All cathodes released (segments dark).
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Glyphs for nibble values 0..F, bit order {g,f,e,d,c,b,a}, active-low.
    localparam logic [6:0] SEG_GLYPH [16] = '{
        7'b1000000,  // 0
        7'b1111001,  // 1
        7'b0100100,  // 2
        7'b0110000,  // 3
        7'b0011001,  // 4
        7'b0010010,  // 5
        7'b0000010,  // 6
        7'b1111000,  // 7
        7'b0000000,  // 8
        7'b0010000,  // 9
        7'b0001000,  // A
        7'b0000011,  // b
        7'b1000110,  // C
        7'b0100001,  // d
        7'b0000110,  // E
        7'b0001110   // F
    };

endpackage : sseg_pkg
`default_nettype wire

// File: rtl/hex_to_sseg.sv
`default_nettype none
// ============================================================================
// Module      : hex_to_sseg
// Description : Purely combinational nibble to seven-segment decoder.
//               Output is active-low, bit order {g,f,e,d,c,b,a}.
// Revision    : 1.0 - initial release
// ============================================================================
module hex_to_sseg
    import sseg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    // Table lookup of the glyph for the selected nibble.
    always_comb begin
        seg = SEG_GLYPH[nibble];
    end

endmodule : hex_to_sseg
`default_nettype wire

// File: rtl/sseg_scan_driver.sv
`default_nettype none
// ============================================================================
// Module      : sseg_scan_driver
// Description : Latches a result word on a load strobe and time-multiplexes
//               its nibbles as hex glyphs across NUM_DIGITS common-anode
//               digits. Anodes and cathodes are active-low; dp is held off.
//               Optional macro SSEG_LEADING_ZERO_BLANK_EN blanks digits above
//               the most significant nonzero nibble (digit 0 always shown).
// Revision    : 1.0 - initial release
// ============================================================================
module sseg_scan_driver
    import sseg_pkg::*;
#(
    parameter int NUM_DIGITS  = MAX_DIGITS,
    parameter int REFRESH_DIV = DEFAULT_REFRESH_DIV,
    parameter int CNT_W       = DEFAULT_CNT_W
)(
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic                    load,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [2:0]              digit_idx
);

    localparam int               VAL_W      = 4 * NUM_DIGITS;
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [2:0]       C_IDX_LAST = 3'(NUM_DIGITS - 1);

    logic [VAL_W-1:0]      r_shadow;
    logic [CNT_W-1:0]      r_cnt;
    logic [2:0]            r_idx;
    logic                  w_tick;

    logic [3:0]            w_nibble;
    logic [6:0]            w_glyph;
    logic [NUM_DIGITS-1:0] w_an_sel;
    logic [NUM_DIGITS-1:0] w_blank_mask;
    logic                  w_blank;

    logic [NUM_DIGITS-1:0] r_an;
    logic [6:0]            r_seg;
    logic [2:0]            r_digit_idx;

    // Shadow register: captures the display word only on the load strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shadow <= '0;
        end else if (load) begin
            r_shadow <= value;
        end
    end

    // One tick per REFRESH_DIV cycles marks the end of a digit slot.
    assign w_tick = (r_cnt == C_CNT_LAST);

    // Refresh counter: 0..REFRESH_DIV-1, restarting on the tick.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Scan index: advances once per slot and wraps after the last digit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx <= '0;
        end else if (w_tick) begin
            r_idx <= (r_idx == C_IDX_LAST) ? 3'd0 : r_idx + 3'd1;
        end
    end

    // Select the nibble, anode pattern and blank flag of the current digit.
    // Everything is taken from the shadow as it stands this cycle, so a
    // load landing on a tick can never mix old and new data in one slot.
    always_comb begin
        w_nibble = 4'h0;
        w_an_sel = '1;
        w_blank  = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (r_idx == 3'(i)) begin
                w_nibble    = r_shadow[4*i +: 4];
                w_an_sel[i] = 1'b0;
                w_blank     = w_blank_mask[i];
            end
        end
    end

`ifdef SSEG_LEADING_ZERO_BLANK_EN
    logic w_zero_run;

    // A digit is blanked when it and every digit above it are zero; digit 0
    // is never blanked so an all-zero word still shows a single "0".
    always_comb begin
        w_blank_mask = '0;
        w_zero_run   = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            w_zero_run      = w_zero_run && (r_shadow[4*i +: 4] == 4'h0);
            w_blank_mask[i] = w_zero_run;
        end
    end
`else
    // Every digit is always shown, leading zeros included.
    assign w_blank_mask = '0;
`endif

    hex_to_sseg u_hex_to_sseg (
        .nibble (w_nibble),
        .seg    (w_glyph)
    );

    // Output register: one-cycle latency from index/shadow to the pins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_an        <= '1;
            r_seg       <= SEG_BLANK;
            r_digit_idx <= 3'd0;
        end else begin
            r_digit_idx <= r_idx;
            if (w_blank) begin
                r_an  <= '1;
                r_seg <= SEG_BLANK;
            end else begin
                r_an  <= w_an_sel;
                r_seg <= w_glyph;
            end
        end
    end

    assign an        = r_an;
    assign seg       = r_seg;
    assign digit_idx = r_digit_idx;
    assign dp        = 1'b1;

endmodule : sseg_scan_driver
`default_nettype wire
